// File: rtl/cpu_sequencer_if.sv
// Control and status lines between the sequencer
// and the 8-bit single-bus datapath.
interface cpu_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              i_aluFlagN;
  logic              i_aluFlagZ;
  logic [DATA_W-1:0] i_instruction;
  logic              o_ctrlAluOE;
  logic              o_ctrlAluSubShiftDir;
  logic [1:0]        o_ctrlAluOp;
  logic              o_ctrlAluBWr;
  logic              o_ctrlRegWr0;
  logic              o_ctrlRegWr1;
  logic              o_ctrlRegBusSel;
  logic              o_ctrlRegBusEn;
  logic              o_ctrlAluSel;
  logic              o_ctrlRamAddressEn;
  logic              o_ctrlRamWriteEn;
  logic              o_ctrlRamReadDataSelect;
  logic              o_ctrlRamOE;
  logic              o_ctrlLoadPC;
  logic              o_ctrlIncrPC;
  logic              o_ctrlPCOe;
  logic              o_halted;

  modport master (
    input  i_aluFlagN, i_aluFlagZ, i_instruction,
    output o_ctrlAluOE, o_ctrlAluSubShiftDir,
    output o_ctrlAluOp, o_ctrlAluBWr,
    output o_ctrlRegWr0, o_ctrlRegWr1,
    output o_ctrlRegBusSel, o_ctrlRegBusEn,
    output o_ctrlAluSel, o_ctrlRamAddressEn,
    output o_ctrlRamWriteEn, o_ctrlRamReadDataSelect,
    output o_ctrlRamOE, o_ctrlLoadPC,
    output o_ctrlIncrPC, o_ctrlPCOe, o_halted
  );

  modport slave (
    output i_aluFlagN, i_aluFlagZ, i_instruction,
    input  o_ctrlAluOE, o_ctrlAluSubShiftDir,
    input  o_ctrlAluOp, o_ctrlAluBWr,
    input  o_ctrlRegWr0, o_ctrlRegWr1,
    input  o_ctrlRegBusSel, o_ctrlRegBusEn,
    input  o_ctrlAluSel, o_ctrlRamAddressEn,
    input  o_ctrlRamWriteEn, o_ctrlRamReadDataSelect,
    input  o_ctrlRamOE, o_ctrlLoadPC,
    input  o_ctrlIncrPC, o_ctrlPCOe, o_halted
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit
// single-bus datapath; one instruction at a time.
module cpu_sequencer #(
  parameter int DATA_W     = 8,
  parameter bit FLAG_LATCH = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_reset,
  cpu_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    RESET, FETCH_A, FETCH_D, DECODE, IMM_A,
    IMM_D, MEM, ALU_B, ALU_Y, HALT
  } state_t;

  localparam logic [2:0] CLS_NOP = 3'd0;
  localparam logic [2:0] CLS_LDI = 3'd1;
  localparam logic [2:0] CLS_LD  = 3'd2;
  localparam logic [2:0] CLS_ST  = 3'd3;
  localparam logic [2:0] CLS_ALU = 3'd4;
  localparam logic [2:0] CLS_JMP = 3'd5;
  localparam logic [2:0] CLS_BR  = 3'd6;
  localparam logic [2:0] CLS_HLT = 3'd7;

  state_t            state;
  logic [DATA_W-1:0] ir;
  logic              flagN;
  logic              flagZ;

  logic [2:0] cls;
  logic       rd;
  logic       rs;
  logic       isNop, isLdi, isLd, isSt;
  logic       isAlu, isJmp, isBr, isHlt;
  logic       condN, condZ, brTake;

  assign cls   = ir[7:5];
  assign rd    = ir[4];
  assign rs    = ir[3];
  assign isNop = (cls == CLS_NOP);
  assign isLdi = (cls == CLS_LDI);
  assign isLd  = (cls == CLS_LD);
  assign isSt  = (cls == CLS_ST);
  assign isAlu = (cls == CLS_ALU);
  assign isJmp = (cls == CLS_JMP);
  assign isBr  = (cls == CLS_BR);
  assign isHlt = (cls == CLS_HLT);

  // cond: 00 Z, 01 !Z, 10 N, 11 !N
  assign condN  = FLAG_LATCH ? flagN : bus.i_aluFlagN;
  assign condZ  = FLAG_LATCH ? flagZ : bus.i_aluFlagZ;
  assign brTake = ir[1] ? (condN ^ ir[0])
                        : (condZ ^ ir[0]);

  // State, instruction register and latched flags.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= RESET;
      ir    <= '0;
      flagN <= 1'b0;
      flagZ <= 1'b0;
    end else begin
      unique case (state)
        RESET:   state <= FETCH_A;
        FETCH_A: state <= FETCH_D;
        FETCH_D: begin
          ir    <= bus.i_instruction;
          state <= DECODE;
        end
        DECODE: begin
          unique case (1'b1)
            isNop:   state <= FETCH_A;
            isHlt:   state <= HALT;
            isAlu:   state <= ALU_B;
            default: state <= IMM_A;
          endcase
        end
        IMM_A:   state <= IMM_D;
        IMM_D:   state <= (isLd || isSt) ? MEM : FETCH_A;
        MEM:     state <= FETCH_A;
        ALU_B:   state <= ALU_Y;
        ALU_Y: begin
          flagN <= bus.i_aluFlagN;
          flagZ <= bus.i_aluFlagZ;
          state <= FETCH_A;
        end
        HALT:    state <= HALT;
        default: state <= RESET;
      endcase
    end
  end

  // Moore decode of control lines from state and IR.
  always_comb begin
    bus.o_ctrlAluOE             = 1'b0;
    bus.o_ctrlAluSubShiftDir    = 1'b0;
    bus.o_ctrlAluOp             = 2'b00;
    bus.o_ctrlAluBWr            = 1'b0;
    bus.o_ctrlRegWr0            = 1'b0;
    bus.o_ctrlRegWr1            = 1'b0;
    bus.o_ctrlRegBusSel         = 1'b0;
    bus.o_ctrlRegBusEn          = 1'b0;
    bus.o_ctrlAluSel            = 1'b0;
    bus.o_ctrlRamAddressEn      = 1'b0;
    bus.o_ctrlRamWriteEn        = 1'b0;
    bus.o_ctrlRamReadDataSelect = 1'b0;
    bus.o_ctrlRamOE             = 1'b0;
    bus.o_ctrlLoadPC            = 1'b0;
    bus.o_ctrlIncrPC            = 1'b0;
    bus.o_ctrlPCOe              = 1'b0;
    bus.o_halted                = (state == HALT);
    unique case (state)
      FETCH_A, IMM_A: begin
        bus.o_ctrlPCOe         = 1'b1;
        bus.o_ctrlRamAddressEn = 1'b1;
      end
      FETCH_D: begin
        bus.o_ctrlRamOE  = 1'b1;
        bus.o_ctrlIncrPC = 1'b1;
      end
      IMM_D: begin
        bus.o_ctrlRamOE = 1'b1;
        unique case (1'b1)
          isLdi: begin
            bus.o_ctrlRegWr0 = ~rd;
            bus.o_ctrlRegWr1 = rd;
            bus.o_ctrlIncrPC = 1'b1;
          end
          isLd || isSt: begin
            bus.o_ctrlRamAddressEn = 1'b1;
            bus.o_ctrlIncrPC       = 1'b1;
          end
          isJmp: bus.o_ctrlLoadPC = 1'b1;
          isBr: begin
            bus.o_ctrlLoadPC = brTake;
            bus.o_ctrlIncrPC = ~brTake;
          end
          default: ;
        endcase
      end
      MEM: begin
        if (isLd) begin
          bus.o_ctrlRamOE  = 1'b1;
          bus.o_ctrlRegWr0 = ~rd;
          bus.o_ctrlRegWr1 = rd;
        end else begin
          bus.o_ctrlRegBusEn   = 1'b1;
          bus.o_ctrlRegBusSel  = rd;
          bus.o_ctrlRamWriteEn = 1'b1;
        end
      end
      ALU_B: begin
        bus.o_ctrlRegBusEn       = 1'b1;
        bus.o_ctrlRegBusSel      = rs;
        bus.o_ctrlAluBWr         = 1'b1;
        bus.o_ctrlAluOp          = ir[2:1];
        bus.o_ctrlAluSubShiftDir = ir[0];
      end
      ALU_Y: begin
        bus.o_ctrlAluSel         = rd;
        bus.o_ctrlAluOp          = ir[2:1];
        bus.o_ctrlAluSubShiftDir = ir[0];
        bus.o_ctrlAluOE          = 1'b1;
        bus.o_ctrlRegWr0         = ~rd;
        bus.o_ctrlRegWr1         = rd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: datapath plant plus an
// instruction-level reference interpreter.
`timescale 1ns/1ps
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_sequencer_if ifc ();

  cpu_sequencer dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (ifc)
  );

  int compared;
  int mismatched;
  int cyc;

  logic [7:0] mem [256];
  logic [7:0] rr [2];
  logic [7:0] pc, addrReg, bReg;
  logic [7:0] initMem [256];
  logic [7:0] initR [2];
  bit         loadNow;
  logic [7:0] aluY, dbus;
  logic [17:0] ctrlVec;

  function automatic logic [7:0] aluFn(
    input logic [7:0] a, input logic [7:0] b,
    input logic [1:0] op, input logic dir);
    case (op)
      2'd0: return dir ? a - b : a + b;
      2'd1: return a & b;
      2'd2: return a | b;
      default: return dir ? (a >> 1) : (a << 1);
    endcase
  endfunction

  assign ctrlVec = {ifc.o_ctrlAluOE, ifc.o_ctrlAluSubShiftDir,
    ifc.o_ctrlAluOp, ifc.o_ctrlAluBWr, ifc.o_ctrlRegWr0,
    ifc.o_ctrlRegWr1, ifc.o_ctrlRegBusSel, ifc.o_ctrlRegBusEn,
    ifc.o_ctrlAluSel, ifc.o_ctrlRamAddressEn, ifc.o_ctrlRamWriteEn,
    ifc.o_ctrlRamReadDataSelect, ifc.o_ctrlRamOE, ifc.o_ctrlLoadPC,
    ifc.o_ctrlIncrPC, ifc.o_ctrlPCOe, ifc.o_halted};

  // Datapath plant: ALU, single bus, flags
  always_comb begin
    aluY = aluFn(rr[ifc.o_ctrlAluSel], bReg,
                 ifc.o_ctrlAluOp, ifc.o_ctrlAluSubShiftDir);
    dbus = 8'h00;
    if (ifc.o_ctrlAluOE) dbus = aluY;
    else if (ifc.o_ctrlRegBusEn) dbus = rr[ifc.o_ctrlRegBusSel];
    else if (ifc.o_ctrlRamOE) dbus = mem[addrReg];
    else if (ifc.o_ctrlPCOe) dbus = pc;
  end
  assign ifc.i_instruction = dbus;
  assign ifc.i_aluFlagN = aluY[7];
  assign ifc.i_aluFlagZ = (aluY == 8'h00);

  // Datapath plant: registers, PC and RAM
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= 8'h00;
      if (loadNow) begin
        mem <= initMem;
        rr  <= initR;
      end
    end else begin
      if (ifc.o_ctrlLoadPC) pc <= dbus;
      else if (ifc.o_ctrlIncrPC) pc <= pc + 8'd1;
      if (ifc.o_ctrlRamAddressEn) addrReg <= dbus;
      if (ifc.o_ctrlAluBWr) bReg <= dbus;
      if (ifc.o_ctrlRegWr0) rr[0] <= dbus;
      if (ifc.o_ctrlRegWr1) rr[1] <= dbus;
      if (ifc.o_ctrlRamWriteEn) mem[addrReg] <= dbus;
    end
  end

  // Reference interpreter state
  logic [7:0] mMem [256];
  logic [7:0] mR [2];
  logic [7:0] mPc;
  logic       mN, mZ;

  task automatic modelRun(input int maxInstr,
                          output int cycles, output bit halted);
    logic [7:0] op, imm, y;
    bit take;
    mMem = initMem; mR = initR;
    mPc = 8'h00; mN = 1'b0; mZ = 1'b0;
    cycles = 0; halted = 1'b0;
    for (int i = 0; i < maxInstr && !halted; i++) begin
      op = mMem[mPc]; mPc = mPc + 8'd1;
      imm = mMem[mPc];
      case (op[7:5])
        3'd0: cycles += 3;
        3'd1: begin mR[op[4]] = imm; mPc = mPc + 8'd1; cycles += 5; end
        3'd2: begin mR[op[4]] = mMem[imm]; mPc = mPc + 8'd1; cycles += 6; end
        3'd3: begin mMem[imm] = mR[op[4]]; mPc = mPc + 8'd1; cycles += 6; end
        3'd4: begin
          y = aluFn(mR[op[4]], mR[op[3]], op[2:1], op[0]);
          mR[op[4]] = y; mN = y[7]; mZ = (y == 8'h00);
          cycles += 5;
        end
        3'd5: begin mPc = imm; cycles += 5; end
        3'd6: begin
          case (op[1:0])
            2'd0: take = mZ;
            2'd1: take = !mZ;
            2'd2: take = mN;
            default: take = !mN;
          endcase
          mPc = take ? imm : mPc + 8'd1;
          cycles += 5;
        end
        default: begin cycles += 3; halted = 1'b1; end
      endcase
    end
  endtask

  task automatic clearInit();
    for (int i = 0; i < 256; i++) initMem[i] = 8'h00;
    initR[0] = 8'h00; initR[1] = 8'h00;
  endtask

  task automatic doReset(input bit load);
    loadNow = load;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; loadNow = 1'b0;
    cyc = -1;
  endtask

  task automatic goTo(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    compared++;
    if (ctrlVec !== 18'h0) begin
      mismatched++;
      $display("FAIL rst_outputs: got %h want %h", ctrlVec, 18'h0);
    end
    clearInit();
    doReset(1'b1);
    goTo(0);
    compared++;
    if (ctrlVec !== 18'h00082) begin
      mismatched++;
      $display("FAIL rst_fetch_a: got %h want %h", ctrlVec, 18'h00082);
    end
    goTo(1);
    compared++;
    if (ctrlVec !== 18'h00014) begin
      mismatched++;
      $display("FAIL fetch_d: got %h want %h", ctrlVec, 18'h00014);
    end
    goTo(3);
    compared++;
    if (ctrlVec !== 18'h00082) begin
      mismatched++;
      $display("FAIL nop_latency: got %h want %h", ctrlVec, 18'h00082);
    end
  endtask

  task automatic test_ldi();
    clearInit();
    initMem[0] = 8'h20; initMem[1] = 8'h05;
    initMem[2] = 8'h01; initMem[3] = 8'hE0;
    doReset(1'b1);
    goTo(4);
    compared++;
    if (ctrlVec !== 18'h01014) begin
      mismatched++;
      $display("FAIL ldi_imm_d: got %h want %h", ctrlVec, 18'h01014);
    end
    goTo(5);
    compared++;
    if (ctrlVec !== 18'h00082 || rr[0] !== 8'h05 || pc !== 8'h02) begin
      mismatched++;
      $display("FAIL ldi_done: got vec=%h r0=%h pc=%h want vec=00082 r0=05 pc=02",
               ctrlVec, rr[0], pc);
    end
    goTo(7);
    compared++;
    if (pc !== 8'h03) begin
      mismatched++;
      $display("FAIL ldi_next_pc: got %h want %h", pc, 8'h03);
    end
  endtask

  task automatic test_alu_sub();
    clearInit();
    initMem[0] = 8'h20; initMem[1] = 8'h05;
    initMem[2] = 8'h30; initMem[3] = 8'h03;
    initMem[4] = 8'h89; initMem[5] = 8'h89;
    initMem[6] = 8'hC2; initMem[7] = 8'h50;
    initMem[8'h50] = 8'h89; initMem[8'h51] = 8'hE0;
    doReset(1'b1);
    goTo(13);
    compared++;
    if (ctrlVec !== 18'h12600) begin
      mismatched++;
      $display("FAIL alu_b: got %h want %h", ctrlVec, 18'h12600);
    end
    goTo(14);
    compared++;
    if (ctrlVec !== 18'h31000) begin
      mismatched++;
      $display("FAIL alu_y: got %h want %h", ctrlVec, 18'h31000);
    end
    goTo(15);
    compared++;
    if (rr[0] !== 8'h02 || rr[1] !== 8'h03) begin
      mismatched++;
      $display("FAIL sub1: got r0=%h r1=%h want r0=02 r1=03", rr[0], rr[1]);
    end
    goTo(20);
    compared++;
    if (rr[0] !== 8'hFF) begin
      mismatched++;
      $display("FAIL sub2: got %h want %h", rr[0], 8'hFF);
    end
    goTo(25);
    compared++;
    if (pc !== 8'h50 || ctrlVec !== 18'h00082) begin
      mismatched++;
      $display("FAIL br_n_taken: got pc=%h vec=%h want pc=50 vec=00082",
               pc, ctrlVec);
    end
    goTo(30);
    compared++;
    if (rr[0] !== 8'hFC) begin
      mismatched++;
      $display("FAIL sub3: got %h want %h", rr[0], 8'hFC);
    end
    goTo(33);
    compared++;
    if (ctrlVec !== 18'h00001) begin
      mismatched++;
      $display("FAIL sub_halt: got %h want %h", ctrlVec, 18'h00001);
    end
  endtask

  task automatic test_branch();
    clearInit();
    initMem[0] = 8'h81; initMem[1] = 8'hC0; initMem[2] = 8'h40;
    initMem[3] = 8'hE0; initMem[8'h40] = 8'hE0;
    doReset(1'b1);
    goTo(9);
    compared++;
    if (ctrlVec !== 18'h00018) begin
      mismatched++;
      $display("FAIL brz_taken_ctl: got %h want %h", ctrlVec, 18'h00018);
    end
    goTo(10);
    compared++;
    if (pc !== 8'h40) begin
      mismatched++;
      $display("FAIL brz_taken_pc: got %h want %h", pc, 8'h40);
    end
    clearInit();
    initMem[0] = 8'hC0; initMem[1] = 8'h40;
    initMem[2] = 8'hE0; initMem[8'h40] = 8'hE0;
    doReset(1'b1);
    goTo(4);
    compared++;
    if (ctrlVec !== 18'h00014) begin
      mismatched++;
      $display("FAIL brz_not_ctl: got %h want %h", ctrlVec, 18'h00014);
    end
    goTo(5);
    compared++;
    if (pc !== 8'h02) begin
      mismatched++;
      $display("FAIL brz_not_pc: got %h want %h", pc, 8'h02);
    end
    goTo(8);
    compared++;
    if (ctrlVec !== 18'h00001 || pc !== 8'h03) begin
      mismatched++;
      $display("FAIL brz_not_halt: got vec=%h pc=%h want vec=00001 pc=03",
               ctrlVec, pc);
    end
    initMem[0] = 8'hC1;
    doReset(1'b1);
    goTo(4);
    compared++;
    if (ctrlVec !== 18'h00018) begin
      mismatched++;
      $display("FAIL brnz_ctl: got %h want %h", ctrlVec, 18'h00018);
    end
  endtask

  task automatic test_st_ld();
    clearInit();
    initMem[0] = 8'h30; initMem[1] = 8'hA5;
    initMem[2] = 8'h70; initMem[3] = 8'h80;
    initMem[4] = 8'h40; initMem[5] = 8'h80;
    initMem[6] = 8'hE0;
    initR[0] = 8'h5A;
    doReset(1'b1);
    goTo(9);
    compared++;
    if (ctrlVec !== 18'h00094) begin
      mismatched++;
      $display("FAIL st_imm_d: got %h want %h", ctrlVec, 18'h00094);
    end
    goTo(10);
    compared++;
    if (ctrlVec !== 18'h00640) begin
      mismatched++;
      $display("FAIL st_mem: got %h want %h", ctrlVec, 18'h00640);
    end
    goTo(11);
    compared++;
    if (ctrlVec !== 18'h00082 || mem[8'h80] !== 8'hA5) begin
      mismatched++;
      $display("FAIL st_done: got vec=%h ram=%h want vec=00082 ram=a5",
               ctrlVec, mem[8'h80]);
    end
    goTo(16);
    compared++;
    if (ctrlVec !== 18'h01010) begin
      mismatched++;
      $display("FAIL ld_mem: got %h want %h", ctrlVec, 18'h01010);
    end
    goTo(17);
    compared++;
    if (ctrlVec !== 18'h00082 || rr[0] !== 8'hA5) begin
      mismatched++;
      $display("FAIL ld_done: got vec=%h r0=%h want vec=00082 r0=a5",
               ctrlVec, rr[0]);
    end
  endtask

  task automatic test_random();
    int cycles;
    bit halted;
    int diffs;
    logic [7:0] b;
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 256; i++) begin
        b = 8'($urandom);
        if (b[7:5] == 3'd7 && $urandom_range(3) != 0) b[7:5] = 3'd4;
        initMem[i] = b;
      end
      initR[0] = 8'($urandom);
      initR[1] = 8'($urandom);
      modelRun(30, cycles, halted);
      doReset(1'b1);
      while (cyc < cycles) begin
        @(negedge clk);
        cyc++;
        compared++;
        if ((int'(ifc.o_ctrlAluOE) + int'(ifc.o_ctrlRegBusEn) +
             int'(ifc.o_ctrlRamOE) + int'(ifc.o_ctrlPCOe)) > 1 ||
            (ifc.o_ctrlLoadPC && ifc.o_ctrlIncrPC) ||
            (ifc.o_ctrlRegWr0 && ifc.o_ctrlRegWr1) ||
            ifc.o_ctrlRamReadDataSelect) begin
          mismatched++;
          $display("FAIL rnd_bus_rule: got vec=%h at cycle %0d want legal",
                   ctrlVec, cyc);
        end
      end
      compared++;
      if (rr[0] !== mR[0] || rr[1] !== mR[1] || pc !== mPc ||
          ifc.o_halted !== halted ||
          (!halted && ctrlVec !== 18'h00082)) begin
        mismatched++;
        $display("FAIL rnd_state p%0d: got r0=%h r1=%h pc=%h h=%b want r0=%h r1=%h pc=%h h=%b",
                 p, rr[0], rr[1], pc, ifc.o_halted, mR[0], mR[1], mPc, halted);
      end
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== mMem[i]) diffs++;
      compared++;
      if (diffs != 0) begin
        mismatched++;
        $display("FAIL rnd_ram p%0d: got %0d differing bytes want 0", p, diffs);
      end
    end
  endtask

  task automatic test_reset_mid();
    clearInit();
    initMem[0] = 8'h20; initMem[1] = 8'h07;
    initMem[2] = 8'h30; initMem[3] = 8'h02;
    initMem[4] = 8'h88; initMem[5] = 8'hE0;
    doReset(1'b1);
    goTo(14);
    compared++;
    if (ctrlVec !== 18'h21000) begin
      mismatched++;
      $display("FAIL mid_alu_y: got %h want %h", ctrlVec, 18'h21000);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if (ctrlVec !== 18'h0) begin
      mismatched++;
      $display("FAIL mid_alu_zero: got %h want %h", ctrlVec, 18'h0);
    end
    @(negedge clk);
    compared++;
    if (rr[0] !== 8'h07) begin
      mismatched++;
      $display("FAIL mid_alu_nowrite: got %h want %h", rr[0], 8'h07);
    end
    clearInit();
    initMem[0] = 8'h30; initMem[1] = 8'h3C;
    initMem[2] = 8'h70; initMem[3] = 8'h90;
    initMem[4] = 8'hE0; initMem[8'h90] = 8'h11;
    doReset(1'b1);
    goTo(10);
    compared++;
    if (ctrlVec !== 18'h00640) begin
      mismatched++;
      $display("FAIL mid_st_mem: got %h want %h", ctrlVec, 18'h00640);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if (ctrlVec !== 18'h0) begin
      mismatched++;
      $display("FAIL mid_st_zero: got %h want %h", ctrlVec, 18'h0);
    end
    @(negedge clk);
    compared++;
    if (mem[8'h90] !== 8'h11) begin
      mismatched++;
      $display("FAIL mid_st_nowrite: got %h want %h", mem[8'h90], 8'h11);
    end
  endtask

  task automatic test_halt();
    clearInit();
    initMem[0] = 8'hE0;
    doReset(1'b1);
    goTo(3);
    compared++;
    if (ctrlVec !== 18'h00001) begin
      mismatched++;
      $display("FAIL halt_enter: got %h want %h", ctrlVec, 18'h00001);
    end
    goTo(25);
    compared++;
    if (ctrlVec !== 18'h00001) begin
      mismatched++;
      $display("FAIL halt_hold: got %h want %h", ctrlVec, 18'h00001);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if (ctrlVec !== 18'h0) begin
      mismatched++;
      $display("FAIL halt_reset: got %h want %h", ctrlVec, 18'h0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    cyc = 0;
    loadNow = 1'b0;
    #1 rst = 1'b1;
    test_reset();
    test_ldi();
    test_alu_sub();
    test_branch();
    test_st_ld();
    test_random();
    test_reset_mid();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
